// File: rtl/skid_buffer.sv
// skid_buffer: registered valid/ready slice with a main+skid register pair; SKID_BUFFER_STATS_EN adds a saturating stall counter
module skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SKID_BUFFER_STATS_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic             in_xfer, out_xfer;
  assign in_xfer   = in_valid && in_ready_q;
  assign out_xfer  = out_valid_q && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (in_xfer) begin
        main_d  = in_data;
        state_d = BUSY;
      end
      BUSY: if (in_xfer && out_xfer) main_d = in_data;
        else if (in_xfer) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (out_xfer) state_d = EMPTY;
      FULL: if (out_xfer) begin
        main_d  = skid_q;
        state_d = BUSY;
      end
      default: state_d = EMPTY;
    endcase
    // handshake outputs are pure functions of the next state, so both stay flop-driven
    out_valid_d = state_d != EMPTY;
    in_ready_d  = state_d != FULL;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end
`ifdef SKID_BUFFER_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  always_comb stall_cnt_d = (out_valid_q && !out_ready && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cnt = stall_cnt_q;
`endif
endmodule
